// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard scheduler: forwarding mux selects and
// multi-cycle sequencer states.
package hazard_pkg;

  // Order matches the execute-stage 4:1 operand mux inputs.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // M has priority over W; register 0 is hardwired and never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] wr_m,
    input logic       we_m,
    input logic [4:0] wr_w,
    input logic       we_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (src != 5'd0 && src == wr_m && we_m)      sel = FWD_MEM;
    else if (src != 5'd0 && src == wr_w && we_w) sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_scheduler_if.sv
// Pipeline <-> hazard scheduler signal bundle. Purely level-based control:
// no valid/ready handshake; every output is a function of the current cycle.
interface hazard_scheduler_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       RsD, RtD, RsE, RtE;
  logic [4:0]       WriteRegE, WriteRegM, WriteRegW;
  logic             RegWriteE, RegWriteM, RegWriteW;
  logic             MemtoRegE, MemtoRegM;
  logic             BranchD, MultiCycleE;
  logic [1:0]       forwardAE, forwardBE;
  logic             forwardAD, forwardBD;
  logic             StallF, StallD, StallE, FlushE, FlushM;
  logic             MCStartE, MCDoneE;
  logic [CNT_W-1:0] StallCount;
  logic [0:0]       mc_state;

  // Pipeline side.
  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, MultiCycleE,
    input  forwardAE, forwardBE, forwardAD, forwardBD, StallF, StallD,
           StallE, FlushE, FlushM, MCStartE, MCDoneE, StallCount, mc_state
  );

  // Hazard scheduler side.
  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, MultiCycleE,
    output forwardAE, forwardBE, forwardAD, forwardBD, StallF, StallD,
           StallE, FlushE, FlushM, MCStartE, MCDoneE, StallCount, mc_state
  );
endinterface

// File: rtl/mc_sequencer.sv
// Holds the execute stage for MC_LATENCY cycles of a multi-cycle op and
// pulses start/done around the occupancy window.
module mc_sequencer
  import hazard_pkg::*;
#(
  parameter int MC_LATENCY = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_multi_cycle,
  output logic       o_mc_start,
  output logic       o_mc_done,
  output logic       o_mc_stall,
  output logic [0:0] o_state
);

  localparam bit         MULTI    = (MC_LATENCY > 1);
  localparam logic [3:0] LOAD_CNT = MULTI ? 4'(MC_LATENCY - 2) : 4'd0;

  logic [0:0] r_state;
  logic [3:0] r_cnt;
  logic [0:0] w_state_nxt;
  logic [3:0] w_cnt_nxt;
  logic       w_start, w_done, w_stall;

  always_comb begin
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_stall     = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (i_multi_cycle) begin
          w_start = 1'b1;
          // Single-cycle latency completes in place without stalling.
          if (MULTI) begin
            w_stall     = 1'b1;
            w_state_nxt = ST_BUSY;
            w_cnt_nxt   = LOAD_CNT;
          end else begin
            w_done = 1'b1;
          end
        end
      end
      default: begin
        if (r_cnt != 4'd0) begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The IDLE decode is combinational on i_multi_cycle, so gate it with reset.
  assign o_mc_start = rst & w_start;
  assign o_mc_done  = rst & w_done;
  assign o_mc_stall = rst & w_stall;
  assign o_state    = r_state;

endmodule

// File: rtl/hazard_scheduler.sv
// Central hazard controller for the 5-stage MIPS pipeline: operand forwarding,
// load-use / branch stalls, multi-cycle sequencing and a stall counter.
module hazard_scheduler
  import hazard_pkg::*;
#(
  parameter int MC_LATENCY = 3,
  parameter int CNT_W      = 32
) (
  input logic               clk,
  input logic               rst,
  hazard_scheduler_if.slave hz
);

  logic [1:0]       w_fwd_a, w_fwd_b;
  logic             w_fwd_ad, w_fwd_bd;
  logic             w_lwstall, w_brstall;
  logic             w_mc_stall, w_mc_start, w_mc_done;
  logic             w_stall_f;
  logic [CNT_W-1:0] r_stall_count;

  mc_sequencer #(.MC_LATENCY(MC_LATENCY)) u_mc_seq (
    .clk           (clk),
    .rst           (rst),
    .i_multi_cycle (hz.MultiCycleE),
    .o_mc_start    (w_mc_start),
    .o_mc_done     (w_mc_done),
    .o_mc_stall    (w_mc_stall),
    .o_state       (hz.mc_state)
  );

  assign w_fwd_a = fwd_sel(hz.RsE, hz.WriteRegM, hz.RegWriteM, hz.WriteRegW, hz.RegWriteW);
  assign w_fwd_b = fwd_sel(hz.RtE, hz.WriteRegM, hz.RegWriteM, hz.WriteRegW, hz.RegWriteW);

  assign w_fwd_ad = (hz.RsD != 5'd0) && (hz.RsD == hz.WriteRegM) && hz.RegWriteM;
  assign w_fwd_bd = (hz.RtD != 5'd0) && (hz.RtD == hz.WriteRegM) && hz.RegWriteM;

  assign w_lwstall = hz.MemtoRegE && ((hz.RtE == hz.RsD) || (hz.RtE == hz.RtD));

  // A branch resolves in D, so a producer still in E, or a load in M, is too late.
  assign w_brstall = hz.BranchD &&
    ((hz.RegWriteE && ((hz.WriteRegE == hz.RsD) || (hz.WriteRegE == hz.RtD))) ||
     (hz.MemtoRegM && ((hz.WriteRegM == hz.RsD) || (hz.WriteRegM == hz.RtD))));

  assign w_stall_f = rst & (w_lwstall | w_brstall | w_mc_stall);

  assign hz.forwardAE  = rst ? w_fwd_a : FWD_RF;
  assign hz.forwardBE  = rst ? w_fwd_b : FWD_RF;
  assign hz.forwardAD  = rst & w_fwd_ad;
  assign hz.forwardBD  = rst & w_fwd_bd;
  assign hz.StallF     = w_stall_f;
  assign hz.StallD     = w_stall_f;
  assign hz.StallE     = w_mc_stall;
  assign hz.FlushM     = w_mc_stall;
  // Flushing ID/EX while E is held would destroy the multi-cycle op.
  assign hz.FlushE     = rst & (w_lwstall | w_brstall) & ~w_mc_stall;
  assign hz.MCStartE   = w_mc_start;
  assign hz.MCDoneE    = w_mc_done;
  assign hz.StallCount = r_stall_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_count <= '0;
    end else if (w_stall_f && (r_stall_count != {CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

endmodule
